// File: rtl/program_loader.sv
// Boot loader: streams INSTR/DATA words into the core's instruction and data memories
// at auto-incrementing addresses, holding the core in reset until a START word.
module program_loader #(
    parameter int DATA_W  = 32,
    parameter int IADDR_W = 7,
    parameter int DADDR_W = 7,
    parameter int I_DEPTH = 128,
    parameter int D_DEPTH = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_kind,
    input  logic [DATA_W-1:0]  in_data,
    output logic               instr_we,
    output logic [IADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0]  instr_wdata,
    output logic               data_we,
    output logic [DADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0]  data_wdata,
    output logic               cpu_rst,
    output logic               running,
    output logic               error,
    output logic [IADDR_W:0]   i_count,
    output logic [DADDR_W:0]   d_count
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    localparam logic [1:0] K_INSTR = 2'd0;
    localparam logic [1:0] K_DATA  = 2'd1;
    localparam logic [1:0] K_SET   = 2'd2;
    localparam logic [1:0] K_START = 2'd3;

    localparam logic [IADDR_W:0]  I_LIM   = (IADDR_W+1)'(I_DEPTH);
    localparam logic [DADDR_W:0]  D_LIM   = (DADDR_W+1)'(D_DEPTH);
    localparam logic [DATA_W-2:0] I_LIM_W = (DATA_W-1)'(I_DEPTH);
    localparam logic [DATA_W-2:0] D_LIM_W = (DATA_W-1)'(D_DEPTH);

    state_e               state_q, state_d;
    logic [IADDR_W:0]     i_ptr_q, i_ptr_d, i_count_q, i_count_d;
    logic [DADDR_W:0]     d_ptr_q, d_ptr_d, d_count_q, d_count_d;
    logic                 instr_we_q, instr_we_d, data_we_q, data_we_d;
    logic [IADDR_W-1:0]   instr_addr_q, instr_addr_d;
    logic [DADDR_W-1:0]   data_addr_q, data_addr_d;
    logic [DATA_W-1:0]    instr_wdata_q, instr_wdata_d, data_wdata_q, data_wdata_d;
    logic                 accept_s, ovf_s, sel_s;
    logic [DATA_W-2:0]    tgt_s;

    assign accept_s = in_valid && (state_q == ST_LOAD);
    assign sel_s    = in_data[DATA_W-1];
    assign tgt_s    = in_data[DATA_W-2:0];

    // The whole SETADDR target is range-checked, not just the bits that fit a pointer.
    always_comb begin
        ovf_s = 1'b0;
        case (in_kind)
            K_INSTR: ovf_s = (i_ptr_q >= I_LIM);
            K_DATA:  ovf_s = (d_ptr_q >= D_LIM);
            K_SET:   ovf_s = sel_s ? (tgt_s >= D_LIM_W) : (tgt_s >= I_LIM_W);
            K_START: ovf_s = 1'b0;
            default: ovf_s = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (accept_s && (in_kind == K_START)) begin
                    state_d = ST_RUN;
                end else if (accept_s && ovf_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_LOAD);
        cpu_rst  = (state_q != ST_RUN);
        running  = (state_q == ST_RUN);
        error    = (state_q == ST_ERR);
    end

    // Addresses and write data hold their last written value between strobes.
    always_comb begin
        i_ptr_d       = i_ptr_q;
        d_ptr_d       = d_ptr_q;
        i_count_d     = i_count_q;
        d_count_d     = d_count_q;
        instr_we_d    = 1'b0;
        data_we_d     = 1'b0;
        instr_addr_d  = instr_addr_q;
        instr_wdata_d = instr_wdata_q;
        data_addr_d   = data_addr_q;
        data_wdata_d  = data_wdata_q;
        if (accept_s && !ovf_s) begin
            case (in_kind)
                K_INSTR: begin
                    instr_we_d    = 1'b1;
                    instr_addr_d  = i_ptr_q[IADDR_W-1:0];
                    instr_wdata_d = in_data;
                    i_ptr_d       = i_ptr_q + (IADDR_W+1)'(1);
                    i_count_d     = (i_count_q == I_LIM) ? i_count_q : i_count_q + (IADDR_W+1)'(1);
                end
                K_DATA: begin
                    data_we_d    = 1'b1;
                    data_addr_d  = d_ptr_q[DADDR_W-1:0];
                    data_wdata_d = in_data;
                    d_ptr_d      = d_ptr_q + (DADDR_W+1)'(1);
                    d_count_d    = (d_count_q == D_LIM) ? d_count_q : d_count_q + (DADDR_W+1)'(1);
                end
                K_SET: begin
                    if (sel_s) begin
                        d_ptr_d = tgt_s[DADDR_W:0];
                    end else begin
                        i_ptr_d = tgt_s[IADDR_W:0];
                    end
                end
                default: begin
                    i_ptr_d = i_ptr_q;
                end
            endcase
        end else begin
            i_ptr_d = i_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_ptr_q       <= '0;
            d_ptr_q       <= '0;
            i_count_q     <= '0;
            d_count_q     <= '0;
            instr_we_q    <= 1'b0;
            data_we_q     <= 1'b0;
            instr_addr_q  <= '0;
            instr_wdata_q <= '0;
            data_addr_q   <= '0;
            data_wdata_q  <= '0;
        end else begin
            i_ptr_q       <= i_ptr_d;
            d_ptr_q       <= d_ptr_d;
            i_count_q     <= i_count_d;
            d_count_q     <= d_count_d;
            instr_we_q    <= instr_we_d;
            data_we_q     <= data_we_d;
            instr_addr_q  <= instr_addr_d;
            instr_wdata_q <= instr_wdata_d;
            data_addr_q   <= data_addr_d;
            data_wdata_q  <= data_wdata_d;
        end
    end

    assign instr_we    = instr_we_q;
    assign instr_addr  = instr_addr_q;
    assign instr_wdata = instr_wdata_q;
    assign data_we     = data_we_q;
    assign data_addr   = data_addr_q;
    assign data_wdata  = data_wdata_q;
    assign i_count     = i_count_q;
    assign d_count     = d_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed boot scenarios plus random streams
// compared every cycle against a behavioural model of the loader.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = 2'd0;
    logic [31:0] in_data = 32'd0;
    logic        instr_we, data_we, cpu_rst, running, error;
    logic [6:0]  instr_addr, data_addr;
    logic [31:0] instr_wdata, data_wdata;
    logic [7:0]  i_count, d_count;

    int checks = 0;
    int errors = 0;

    program_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_data(in_data),
        .instr_we(instr_we), .instr_addr(instr_addr), .instr_wdata(instr_wdata),
        .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .cpu_rst(cpu_rst), .running(running), .error(error),
        .i_count(i_count), .d_count(d_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = loading, 1 = running, 2 = error.
    int          m_mode = 0, m_ip = 0, m_dp = 0, m_ic = 0, m_dc = 0;
    bit          m_iwe = 0, m_dwe = 0, m_live = 0;
    int          m_iaddr = 0, m_daddr = 0;
    logic [31:0] m_iwd = 32'd0, m_dwd = 32'd0;

    always @(posedge clk) begin
        int tgt;
        if (rst) begin
            m_mode = 0; m_ip = 0; m_dp = 0; m_ic = 0; m_dc = 0;
            m_iwe = 0; m_dwe = 0; m_iaddr = 0; m_daddr = 0;
            m_iwd = 32'd0; m_dwd = 32'd0; m_live = 1;
        end else begin
            m_iwe = 0;
            m_dwe = 0;
            if (m_mode == 0 && in_valid) begin
                case (in_kind)
                    2'd0: if (m_ip >= 128) m_mode = 2;
                          else begin
                              m_iwe = 1; m_iaddr = m_ip; m_iwd = in_data; m_ip++;
                              if (m_ic < 128) m_ic++;
                          end
                    2'd1: if (m_dp >= 128) m_mode = 2;
                          else begin
                              m_dwe = 1; m_daddr = m_dp; m_dwd = in_data; m_dp++;
                              if (m_dc < 128) m_dc++;
                          end
                    2'd2: begin
                        tgt = int'(in_data & 32'h7FFF_FFFF);
                        if (tgt >= 128) m_mode = 2;
                        else if (in_data[31]) m_dp = tgt;
                        else m_ip = tgt;
                    end
                    default: m_mode = 1;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready", 64'(in_ready), 64'(m_mode == 0));
            chk("cpu_rst",  64'(cpu_rst),  64'(m_mode != 1));
            chk("running",  64'(running),  64'(m_mode == 1));
            chk("error",    64'(error),    64'(m_mode == 2));
            chk("instr_we", 64'(instr_we), 64'(m_iwe));
            chk("data_we",  64'(data_we),  64'(m_dwe));
            chk("instr_addr",  64'(instr_addr),  64'(m_iaddr));
            chk("instr_wdata", 64'(instr_wdata), 64'(m_iwd));
            chk("data_addr",   64'(data_addr),   64'(m_daddr));
            chk("data_wdata",  64'(data_wdata),  64'(m_dwd));
            chk("i_count", 64'(i_count), 64'(m_ic));
            chk("d_count", 64'(d_count), 64'(m_dc));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present one word for one edge; returns 1 time unit after that edge.
    task automatic send(input logic [1:0] k, input logic [31:0] d);
        in_valid = 1'b1;
        in_kind  = k;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int r;
        logic [31:0] d;
        do_reset();
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_outs", {instr_we, data_we, running, error, i_count, d_count}, 64'd0);

        // Two instructions, consecutive strobes
        send(2'd0, 32'h1022003F);
        chk("t1_we0", {instr_we, instr_addr, instr_wdata}, {1'b1, 7'd0, 32'h1022003F});
        send(2'd0, 32'h20220003);
        chk("t1_we1", {instr_we, instr_addr, instr_wdata}, {1'b1, 7'd1, 32'h20220003});
        chk("t1_icount", 64'(i_count), 64'd2);

        send(2'd2, 32'h80000005);
        send(2'd1, 32'd12);
        chk("t2_data", {data_we, data_addr, data_wdata}, {1'b1, 7'd5, 32'd12});
        chk("t2_icount", 64'(i_count), 64'd2);

        send(2'd3, 32'd0);
        chk("t3_run", {cpu_rst, running, in_ready}, {1'b0, 1'b1, 1'b0});
        send(2'd0, 32'hDEAD_BEEF);
        chk("t3_ignored", {instr_we, in_ready, i_count}, {1'b0, 1'b0, 8'd2});

        // Fill instruction memory then overflow
        do_reset();
        for (int i = 0; i < 128; i++) send(2'd0, 32'h1000 + 32'(i));
        chk("t4_last", {instr_we, instr_addr, instr_wdata, i_count}, {1'b1, 7'd127, 32'h107F, 8'd128});
        send(2'd0, 32'h5555);
        chk("t4_ovf", {instr_we, error, cpu_rst, in_ready, i_count}, {1'b0, 1'b1, 1'b1, 1'b0, 8'd128});

        do_reset();
        send(2'd2, 32'h00000080);
        chk("t5_setaddr", {error, cpu_rst, running}, {1'b1, 1'b1, 1'b0});

        // Reset wins over a same-edge accept, and kills a pending strobe
        do_reset();
        in_valid = 1'b1; in_kind = 2'd1; in_data = 32'h55; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("t6_noaccept", {data_we, d_count, in_ready}, {1'b0, 8'd0, 1'b1});
        send(2'd1, 32'h77);
        chk("t6_strobe", {data_we, data_wdata}, {1'b1, 32'h77});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_drop", {data_we, data_addr, data_wdata, d_count}, {1'b0, 7'd0, 32'd0, 8'd0});

        // Random streams
        for (int e = 0; e < 8; e++) begin
            do_reset();
            for (int c = 0; c < 500; c++) begin
                rst = ($urandom_range(0, 299) == 0);
                in_valid = ($urandom_range(0, 3) != 0);
                r = int'($urandom_range(0, 199));
                if (r < 90)       in_kind = 2'd0;
                else if (r < 170) in_kind = 2'd1;
                else if (r < 198) in_kind = 2'd2;
                else              in_kind = 2'd3;
                d = $urandom;
                if (in_kind == 2'd2) begin
                    d = {d[31], 31'($urandom_range(0, 131))};
                end
                in_data = d;
                @(posedge clk); #1;
            end
            rst = 1'b0;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
